// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_queue
// Description : DEPTH-entry instruction/PC queue between fetch and decode
//               with valid/ready handshakes on both sides, redirect flush,
//               and head-of-queue branch-class decode (pc_src).
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        pc_src,
    output logic [CNT_W-1:0]  count
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_instr_mem [DEPTH];
    logic [DATA_W-1:0]  r_pc_mem    [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [5:0]         w_op;
    logic [5:0]         w_func;

    // Handshake status comes from registered occupancy only, so in_ready
    // never depends on out_ready (a full queue refuses a push even while
    // it is being popped).
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    // Pointer and occupancy update; reset outranks flush, and flush
    // discards any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are never cleared since outputs are masked
    // whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
        end
    end

    // Head entry, forced to a zero bubble while empty.
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = r_instr_mem[r_rd_ptr];
            out_pc    = r_pc_mem[r_rd_ptr];
        end
    end

    assign w_op   = out_instr[31:26];
    assign w_func = out_instr[5:0];

    // Branch-class decode of the head instruction for the next-PC mux.
    always_comb begin
        pc_src = 2'd0;
        if (out_valid) begin
            case (w_op)
                6'b000100: pc_src = 2'd1;
                6'b000010,
                6'b000011: pc_src = 2'd2;
                6'b000000: pc_src = (w_func == 6'b001000) ? 2'd3 : 2'd0;
                default:   pc_src = 2'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fetch_queue
// Description : Directed, table-driven self-checking bench for the
//               fetch queue, plus a hand-written steady-state wrap sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc;
    logic              out_ready;
    logic              flush;
    logic [1:0]        pc_src;
    logic [CNT_W-1:0]  count;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        int          e_cnt;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        int          e_src;
    } vec_t;

    vec_t vecs[$];

    if_id_fetch_queue #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .out_ready(out_ready),
        .flush    (flush),
        .pc_src   (pc_src),
        .count    (count)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%08h required=0x%08h",
                     name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic e_ov, input logic e_ir,
                       input int e_cnt, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input int e_src);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.instr = instr; v.pc = pc;
        v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_src = e_src;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, sample outputs 1 unit after.
    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] instr, input logic [31:0] pc,
                         input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int idx, input logic e_ov, input logic e_ir,
                              input int e_cnt, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input int e_src);
        chk("out_valid", idx, 32'(out_valid), 32'(e_ov));
        chk("in_ready",  idx, 32'(in_ready),  32'(e_ir));
        chk("count",     idx, 32'(count),     32'(e_cnt));
        chk("out_instr", idx, out_instr,      e_instr);
        chk("out_pc",    idx, out_pc,         e_pc);
        chk("pc_src",    idx, 32'(pc_src),    32'(e_src));
    endtask

    initial begin
        logic [31:0] pc_w;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        //   rst fl iv instr         pc        ordy  ov ir cnt e_instr       e_pc      src
        add(1, 0, 0, 32'h0,         32'h0,    0,    0, 1, 0, 32'h0,         32'h0,    0);
        add(0, 0, 1, 32'h3C011234, 32'h3000, 0,    1, 1, 1, 32'h3C011234, 32'h3000, 0);
        add(0, 0, 1, 32'h10220003, 32'h3004, 0,    1, 1, 2, 32'h3C011234, 32'h3000, 0);
        add(0, 0, 1, 32'h0C000C00, 32'h3008, 0,    1, 1, 3, 32'h3C011234, 32'h3000, 0);
        add(0, 0, 1, 32'h03E00008, 32'h300C, 0,    1, 0, 4, 32'h3C011234, 32'h3000, 0);
        // fifth push while full is dropped
        add(0, 0, 1, 32'h11111111, 32'h3010, 0,    1, 0, 4, 32'h3C011234, 32'h3000, 0);
        // pop while full: simultaneous push still refused
        add(0, 0, 1, 32'h22222222, 32'h3020, 1,    1, 1, 3, 32'h10220003, 32'h3004, 1);
        add(0, 0, 0, 32'h0,         32'h0,    1,    1, 1, 2, 32'h0C000C00, 32'h3008, 2);
        add(0, 0, 0, 32'h0,         32'h0,    1,    1, 1, 1, 32'h03E00008, 32'h300C, 3);
        add(0, 0, 0, 32'h0,         32'h0,    1,    0, 1, 0, 32'h0,         32'h0,    0);
        // pop attempt on empty queue has no effect
        add(0, 0, 0, 32'h0,         32'h0,    1,    0, 1, 0, 32'h0,         32'h0,    0);
        // all-zero instruction and a non-jr R-type decode as sequential
        add(0, 0, 1, 32'h00000000, 32'h4000, 0,    1, 1, 1, 32'h00000000, 32'h4000, 0);
        add(0, 0, 1, 32'h00221820, 32'h4004, 1,    1, 1, 1, 32'h00221820, 32'h4004, 0);
        add(0, 0, 1, 32'h10220003, 32'h4008, 0,    1, 1, 2, 32'h00221820, 32'h4004, 0);
        add(0, 0, 1, 32'h0C000C00, 32'h400C, 0,    1, 1, 3, 32'h00221820, 32'h4004, 0);
        // flush with push and pop in the same cycle
        add(0, 1, 1, 32'h11111111, 32'h4010, 1,    0, 1, 0, 32'h0,         32'h0,    0);
        add(0, 0, 1, 32'h10220003, 32'h5000, 0,    1, 1, 1, 32'h10220003, 32'h5000, 1);
        add(0, 0, 1, 32'h03E00008, 32'h5004, 0,    1, 1, 2, 32'h10220003, 32'h5000, 1);
        // reset and flush together
        add(1, 1, 1, 32'h11111111, 32'h5008, 1,    0, 1, 0, 32'h0,         32'h0,    0);
        add(0, 0, 1, 32'h3C016000, 32'h6000, 0,    1, 1, 1, 32'h3C016000, 32'h6000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].instr,
                  vecs[i].pc, vecs[i].ordy);
            check_outs(i, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_cnt,
                       vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_src);
        end

        // Steady state at count=2: push and pop every cycle so both
        // pointers wrap several times; head PC advances by 4 per cycle.
        drive(0, 0, 1, 32'h20006004, 32'h6004, 0);
        check_outs(100, 1, 1, 2, 32'h3C016000, 32'h6000, 0);
        drive(0, 0, 1, 32'h20006008, 32'h6008, 1);
        check_outs(101, 1, 1, 2, 32'h20006004, 32'h6004, 0);
        for (int k = 1; k < 10; k++) begin
            pc_w = 32'h6008 + 32'(4 * k);
            drive(0, 0, 1, 32'h20000000 + pc_w, pc_w, 1);
            check_outs(101 + k, 1, 1, 2, 32'h20000000 + pc_w - 32'h4,
                       pc_w - 32'h4, 0);
        end
        // Drain the last two entries.
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        check_outs(200, 1, 1, 1, 32'h2000602C, 32'h602C, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        check_outs(201, 0, 1, 0, 32'h0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
